// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter driven by a 16x oversampling tick
//
// Sends one start bit, DBIT data bits (LSB first), then a stop period of
// SB_TICK ticks. Each start and data bit lasts 16 ticks.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   s_tick       one-clock oversampling tick from the baud timer
//   tx_start     send request, sampled only while idle
//   din          data word, captured when tx_start is accepted
//   tx           registered serial line, idles high
//   tx_busy      high whenever a frame is in progress
//   tx_done_tick one-clock pulse on the terminal stop tick
module uart_tx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            tx_start,
   input  logic [DBIT-1:0] din,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int NW = $clog2(DBIT);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]      state_reg, state_next;
   logic [SW-1:0]   s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            tx_reg, tx_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         s_reg     <= '0;
         n_reg     <= '0;
         b_reg     <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         s_reg     <= s_next;
         n_reg     <= n_next;
         b_reg     <= b_next;
         tx_reg    <= tx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      s_next       = s_reg;
      n_next       = n_reg;
      b_next       = b_reg;
      tx_next      = tx_reg;
      tx_done_tick = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (tx_start) begin
               b_next     = din;
               s_next     = '0;
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (s_tick) begin
               if (s_reg == SW'(15)) begin
                  s_next     = '0;
                  n_next     = '0;
                  tx_next    = b_reg[0];
                  state_next = DATA;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end
         DATA: begin
            tx_next = b_reg[0];
            if (s_tick) begin
               if (s_reg == SW'(15)) begin
                  s_next = '0;
                  b_next = b_reg >> 1;
                  if (n_reg == NW'(DBIT - 1)) begin
                     tx_next    = 1'b1;
                     state_next = STOP;
                  end else begin
                     n_next  = n_reg + NW'(1);
                     // next bit is already in position 1 of the old word
                     tx_next = b_reg[1];
                  end
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end
         default: begin
            tx_next = 1'b1;
            if (s_tick) begin
               if (s_reg == SW'(SB_TICK - 1)) begin
                  // combinational so the pulse lines up with the last stop tick
                  tx_done_tick = 1'b1;
                  state_next   = IDLE;
               end else begin
                  s_next = s_reg + SW'(1);
               end
            end
         end
      endcase
   end

   assign tx      = tx_reg;
   assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       s_tick = 1'b0;
   logic       tx_start = 1'b0;
   logic [8:0] din = '0;
   int         sel = 0;
   int         tick_period = 55;
   int         tcnt = 0;

   logic tx8, busy8, done8, tx32, busy32, done32, tx7, busy7, done7;
   logic m_tx, m_busy, m_done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tcnt >= tick_period - 1) begin
         tcnt   <= 0;
         s_tick <= 1'b1;
      end else begin
         tcnt   <= tcnt + 1;
         s_tick <= 1'b0;
      end
   end

   uart_tx #(.DBIT(8), .SB_TICK(16)) u8 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start && sel == 0),
      .din(din[7:0]), .tx(tx8), .tx_busy(busy8), .tx_done_tick(done8));
   uart_tx #(.DBIT(8), .SB_TICK(32)) u32 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start && sel == 1),
      .din(din[7:0]), .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32));
   uart_tx #(.DBIT(7), .SB_TICK(16)) u7 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start && sel == 2),
      .din(din[6:0]), .tx(tx7), .tx_busy(busy7), .tx_done_tick(done7));

   assign m_tx   = (sel == 0) ? tx8   : (sel == 1) ? tx32   : tx7;
   assign m_busy = (sel == 0) ? busy8 : (sel == 1) ? busy32 : busy7;
   assign m_done = (sel == 0) ? done8 : (sel == 1) ? done32 : done7;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   typedef struct {
      int         sel;
      logic [8:0] d;
      int         dbit;
      int         sb;
      int         per;
      bit         glitch;
   } vec_t;

   task automatic run_frame(input vec_t v);
      int k, bad, done_cnt, done_at, total, cyc, limit, gl;
      logic [8:0] word;
      logic exp_tx;
      total = 16 * (1 + v.dbit) + v.sb;
      limit = (total + 4) * (v.per + 1) + 100;
      k = 0; bad = 0; done_cnt = 0; done_at = -1; cyc = 0; gl = 0; word = '0;
      tick_period = v.per;
      sel = v.sel;
      repeat (3) @(negedge clk);
      din = v.d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      chk($sformatf("accept_tx_low[%0h]", v.d), int'(m_tx), 0);
      chk($sformatf("accept_busy[%0h]", v.d), int'(m_busy), 1);
      while (k < total + 2 && cyc < limit) begin
         if (gl == 1) begin
            tx_start = 1'b0;
            din = v.d;
            gl = 2;
         end
         if (m_done) begin
            done_cnt++;
            done_at = k;
         end
         if (s_tick) begin
            if (k < 16) exp_tx = 1'b0;
            else if (k < 16 * (1 + v.dbit)) exp_tx = v.d[(k - 16) / 16];
            else exp_tx = 1'b1;
            if (m_tx !== exp_tx) bad++;
            if (k >= 16 && k < 16 * (1 + v.dbit) && (k % 16) == 8)
               word[(k - 16) / 16] = m_tx;
            k++;
         end
         if (v.glitch && gl == 0 && k == 40) begin
            din = 9'h0FF;
            tx_start = 1'b1;
            gl = 1;
         end
         @(negedge clk);
         cyc++;
      end
      tx_start = 1'b0;
      chk($sformatf("tick_budget[%0h]", v.d), int'(cyc < limit), 1);
      chk($sformatf("bad_levels[%0h]", v.d), bad, 0);
      chk($sformatf("data_word[%0h]", v.d), int'(word), int'(v.d));
      chk($sformatf("done_count[%0h]", v.d), done_cnt, 1);
      chk($sformatf("done_tick_index[%0h]", v.d), done_at, total - 1);
      chk($sformatf("idle_after[%0h]", v.d), int'({m_busy, m_tx}), 1);
   endtask

   vec_t vec[7];

   initial begin
      int bad, c, d1, d2, done_n;
      logic [7:0] word;

      vec[0] = '{0, 9'h0A5, 8, 16, 55, 1'b0};
      vec[1] = '{0, 9'h03C, 8, 16, 5, 1'b1};
      vec[2] = '{1, 9'h080, 8, 32, 4, 1'b0};
      vec[3] = '{1, 9'h05A, 8, 32, 3, 1'b0};
      vec[4] = '{2, 9'h041, 7, 16, 4, 1'b0};
      vec[5] = '{0, 9'h0FF, 8, 16, 1, 1'b0};
      vec[6] = '{2, 9'h03E, 7, 16, 2, 1'b0};

      // reset held, then a long idle stretch with no request
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", int'({tx8, busy8, done8, tx32, busy32, tx7, busy7}), 7'b1001010);
      reset = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if ({tx8, busy8, done8, tx32, busy32, done32, tx7, busy7, done7} !== 9'b100100100) bad++;
      end
      chk("idle_100_clocks", bad, 0);

      for (int i = 0; i < 7; i++) run_frame(vec[i]);

      // back-to-back frames with a tick every clock
      tick_period = 1;
      sel = 0;
      repeat (3) @(negedge clk);
      din = 9'h000;
      tx_start = 1'b1;
      c = 0; d1 = -1; d2 = -1; done_n = 0; word = '0;
      while (c < 400 && d2 < 0) begin
         @(negedge clk);
         c++;
         if (c == 1) din = 9'h055;
         if (done8) begin
            done_n++;
            if (d1 < 0) d1 = c;
            else d2 = c;
         end
         if (d1 >= 0 && c == d1 + 1) chk("b2b_idle_high", int'(tx8), 1);
         if (d1 >= 0 && c == d1 + 2) chk("b2b_restart_low", int'(tx8), 0);
         if (d1 >= 0 && c >= d1 + 18 && c < d1 + 146 && ((c - d1 - 18) % 16) == 8)
            word[(c - d1 - 18) / 16] = tx8;
      end
      tx_start = 1'b0;
      chk("b2b_first_frame_clocks", d1, 160);
      chk("b2b_done_spacing", d2 - d1, 161);
      chk("b2b_second_word", int'(word), 8'h55);
      repeat (20) begin
         @(negedge clk);
         if (done8) done_n++;
      end
      chk("b2b_done_count", done_n, 2);
      chk("b2b_idle_after", int'({busy8, tx8}), 1);

      // asynchronous reset in the middle of the data bits
      tick_period = 2;
      repeat (3) @(negedge clk);
      din = 9'h000;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (60) @(negedge clk);
      chk("mid_data_before_reset", int'({busy8, tx8}), 2);
      #2 reset = 1'b0;
      #1 chk("mid_data_async_reset", int'({busy8, tx8, done8}), 3'b010);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      chk("after_reset_idle", int'({busy8, tx8}), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that consumes the 16x-oversampling baud tick produced by the `timer` block and shifts a parallel data word out as one start bit, DBIT data bits (LSB first), and a stop period of SB_TICK ticks. It sits between the host-side write logic and the `tx` pin. It is the transmit end of the tick interface that `timer` drives; for example, DVSR = 54 at 100 MHz gives about 115200 baud × 16.

## Interface
- `DBIT`, 8, number of data bits per frame; legal range 5–9.
- `SB_TICK`, 16, stop-period length in s_ticks: 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_tick`  in  1  one-clk-wide oversampling tick from `timer`; arrives every DVSR+1 clocks.
- `tx_start`  in  1  request to send; sampled only in IDLE.
- `din`  in  DBIT  data word; captured on the clock edge that accepts `tx_start`.
- `tx`  out  1  serial line, registered; idle level is 1.
- `tx_busy`  out  1  high whenever state ≠ IDLE.
- `tx_done_tick`  out  1  one-clk pulse at the end of the stop period.

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers:
  - `s`: tick counter, width max(4, clog2(SB_TICK)).
  - `n`: bit counter, width clog2(DBIT).
  - `b`: shift register, DBIT bits.
  - `tx_reg`: drives `tx`.
- IDLE: `tx_reg`=1. If `tx_start`=1: b←din, s←0, `tx_reg`←0, go to START.
- START: `tx_reg`=0. On each s_tick, s increments. On an s_tick with s=15: s←0, n←0, `tx_reg`←b[0], go to DATA.
- DATA: `tx_reg`=b[0]. On each s_tick, s increments. On an s_tick with s=15:
  - s←0, b←b>>1.
  - If n=DBIT-1: `tx_reg`←1, go to STOP.
  - Otherwise: n←n+1, `tx_reg`←new b[0].
- STOP: `tx_reg`=1. On each s_tick, s increments. On an s_tick with s=SB_TICK-1: `tx_done_tick`=1 for that cycle, go to IDLE.
- Cycles without s_tick hold all counters.
- `tx_start` is ignored outside IDLE, including the cycle in which `tx_done_tick` is high. `din` changes after capture have no effect.
- Counters never wrap, because every state exits at its terminal count.

## Timing
- Reset (`reset`=0), applied asynchronously, including mid-frame:
  - state=IDLE, `tx`=1, `tx_busy`=0, `tx_done_tick`=0, s=0, n=0, b=0.
- After reset deasserts, the first accepted `tx_start` takes effect on the next rising edge.
- `tx` falls and `tx_busy` rises one clock after the edge that samples `tx_start`=1 in IDLE.
- Line timing in s_ticks:
  - Start bit: exactly 16 s_ticks.
  - Each data bit: exactly 16 s_ticks.
  - Stop period: SB_TICK s_ticks.
- Frame length is 16·(1+DBIT)+SB_TICK s_ticks, plus up to one s_tick period of alignment for the start bit, since the first s_tick after acceptance may come at any phase.
- `tx_done_tick` asserts in the same cycle as the terminal STOP s_tick, and lasts exactly one clock.
- `tx_busy` falls on the clock after `tx_done_tick`.
- The earliest back-to-back restart is a `tx_start` sampled on the clock after `tx_done_tick`. In that case `tx` goes low two clocks after `tx_done_tick`.
- If s_tick is stuck at 1 (a tick every clock), each bit lasts exactly 16 clocks.

## Test plan
- **Reset behaviour.** Hold `reset`=0 for 5 clocks, release, leave `tx_start`=0 for 100 clocks → `tx`=1, `tx_busy`=0, `tx_done_tick`=0 throughout. Then assert `reset`=0 mid-DATA → `tx`=1 and `tx_busy`=0 immediately, with no clock edge needed.
- **Single frame.** DBIT=8, SB_TICK=16, s_tick every 55 clks, send din=8'hA5 → `tx` shows 0,1,0,1,0,0,1,0,1 then 1. Each level lasts 16×55 clks, the stop lasts 16×55 clks, and exactly one `tx_done_tick` pulse occurs.
- **Busy-time request ignored.** Send 8'h3C, then pulse `tx_start` with din=8'hFF during DATA → the serialized bits still decode to 8'h3C, and exactly one `tx_done_tick` occurs.
- **Back-to-back frames.** Hold `tx_start`=1 continuously, s_tick=1 every clock, din=8'h00 then 8'h55 → each frame is 160 clks. The frames are separated by exactly one idle-high clock plus the acceptance clock, and there are two `tx_done_tick` pulses.
- **Two stop bits.** SB_TICK=32, din=8'h80 → the stop-high period is 32 s_ticks before `tx_done_tick`. A start bit that begins on the next `tx_start` follows correctly.
- **Short word.** DBIT=7, din=7'h41 → 7 data bits (1,0,0,0,0,0,1), and the frame is 16·8+16 s_ticks.
